// File: rtl/btn_conditioner.sv
// Pushbutton front end: per-button synchroniser and debouncer, plus an execute strobe carrying a select snapshot.
// Optional auto-repeat of the execute strobe while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnl_raw,
    input  logic       btnc_raw,
    input  logic       btnr_raw,
    input  logic       btnd_raw,
    output logic       btnl,
    output logic       btnc,
    output logic       btnr,
    output logic       op_valid,
    output logic [2:0] op_sel
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("btn_conditioner: SYNC_STAGES must be 2 or 3");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("btn_conditioner: REPEAT_CYCLES must be at least 2");
    end

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } db_state_t;

    // Bit order: 3 = left, 2 = centre, 1 = right, 0 = execute (down).
    logic [3:0] w_raw;
    logic [3:0] w_db;
    logic [3:0] w_toggle;

    assign w_raw = {btnl_raw, btnc_raw, btnr_raw, btnd_raw};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_sync;
        db_state_t              r_state;
        db_state_t              w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   r_db;
        logic                   w_db_nxt;
        logic                   w_tog;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
            end
        end

        assign w_sync = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_db    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_db    <= w_db_nxt;
            end
        end

        // Any return of the synchronised level to the accepted one restarts the count.
        always_comb begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
            w_db_nxt    = r_db;
            w_tog       = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_sync != r_db) begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_sync == r_db) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_STABLE;
                        w_db_nxt    = ~r_db;
                        w_tog       = 1'b1;
                    end else begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                end
            endcase
        end

        assign w_db[gi]     = r_db;
        assign w_toggle[gi] = w_tog;
    end

    logic w_press;
    logic w_fire;

    assign w_press = w_toggle[0] & ~w_db[0];

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic             w_release;
    logic             w_repeat;
    logic [REP_W-1:0] r_rep_cnt;

    assign w_release = w_toggle[0] & w_db[0];
    // A repeat that would coincide with the release edge is suppressed.
    assign w_repeat  = w_db[0] & ~w_release & (r_rep_cnt == REP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (!w_db[0] || w_release || w_repeat) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_fire = w_press | w_repeat;
`else
    assign w_fire = w_press;
`endif

    logic       r_op_valid;
    logic [2:0] r_op_sel;

    // Snapshot uses the pre-edge select levels, so a select settling on this edge is seen at its old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_valid <= 1'b0;
            r_op_sel   <= 3'b000;
        end else begin
            r_op_valid <= w_fire;
            if (w_fire) begin
                r_op_sel <= w_db[3:1];
            end
        end
    end

    assign btnl     = w_db[3];
    assign btnc     = w_db[2];
    assign btnr     = w_db[1];
    assign op_valid = r_op_valid;
    assign op_sel   = r_op_sel;

endmodule
